// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue-stage controller between the decoder and the ALU. Owns the ID/EX
//   pipeline register, forwards MEM/WB results into the ALU operands, inserts
//   a single bubble on a load-use hazard, squashes on redirect, and keeps a
//   saturating count of load-use bubble cycles.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid / id_ready      decoder handshake (id_ready is combinational)
//   id_op .. id_imm          decoded instruction fields and regfile values
//   ex_stall                 downstream wait, freezes the EX register
//   flush                    redirect, kills ID and EX contents
//   mem_* / wb_*             destination info of the MEM and WB stages
//   ex_valid .. ex_imm       registered fields to the ALU
//   ex_src1 / ex_src2        forwarded operands (mux after the register)
//   stall_cnt                saturating count of load-use bubble cycles

`ifndef ALU_OP_NUM
`define ALU_OP_NUM 12
`endif

module alu_issue_ctrl #(
  parameter int unsigned OP_W = `ALU_OP_NUM
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            id_valid,
  output logic            id_ready,
  input  logic [OP_W-1:0] id_op,
  input  logic [4:0]      id_rd_id,
  input  logic            id_rd_we,
  input  logic [3:0]      id_mem_we,
  input  logic [4:0]      id_mem_re,
  input  logic [4:0]      id_rs1_id,
  input  logic [4:0]      id_rs2_id,
  input  logic            id_rs1_use,
  input  logic            id_rs2_use,
  input  logic [31:0]     id_src1,
  input  logic [31:0]     id_src2,
  input  logic [31:0]     id_imm,

  input  logic            ex_stall,
  input  logic            flush,

  input  logic [4:0]      mem_rd_id,
  input  logic            mem_rd_we,
  input  logic            mem_re_nz,
  input  logic [31:0]     mem_data,

  input  logic [4:0]      wb_rd_id,
  input  logic            wb_rd_we,
  input  logic [31:0]     wb_data,

  output logic            ex_valid,
  output logic [OP_W-1:0] ex_op,
  output logic [4:0]      ex_rd_id,
  output logic            ex_rd_we,
  output logic [3:0]      ex_mem_we,
  output logic [4:0]      ex_mem_re,
  output logic [31:0]     ex_imm,
  output logic [31:0]     ex_src1,
  output logic [31:0]     ex_src2,
  output logic [31:0]     stall_cnt
);

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
    logic [4:0]      rd_id;
    logic            rd_we;
    logic [3:0]      mem_we;
    logic [4:0]      mem_re;
    logic [4:0]      rs1_id;
    logic            rs1_use;
    logic [4:0]      rs2_id;
    logic            rs2_use;
    logic [31:0]     src1;
    logic [31:0]     src2;
    logic [31:0]     imm;
  } ex_reg_t;

  // What the EX register does on the next edge (reset handled separately).
  typedef enum logic [1:0] {
    ISSUE_NORMAL,
    ISSUE_HAZARD,
    ISSUE_HOLD,
    ISSUE_FLUSH
  } issue_act_e;

  ex_reg_t    ex_q;
  ex_reg_t    ex_d;
  issue_act_e act;
  logic       hz;
  logic       rs1_hit;
  logic       rs2_hit;
  logic [31:0] stall_cnt_q;

  // Load-use hazard: EX holds a load whose destination ID wants to read.
  // x0 is excluded so a load to x0 never stalls.
  always_comb begin
    rs1_hit = id_rs1_use && (id_rs1_id == ex_q.rd_id);
    rs2_hit = id_rs2_use && (id_rs2_id == ex_q.rd_id);
    hz      = ex_q.valid && (ex_q.mem_re != '0) && (ex_q.rd_id != '0) &&
              id_valid && (rs1_hit || rs2_hit);
  end

  always_comb begin
    act = ISSUE_NORMAL;
    if (flush) begin
      act = ISSUE_FLUSH;
    end else if (ex_stall) begin
      act = ISSUE_HOLD;
    end else if (hz) begin
      act = ISSUE_HAZARD;
    end
  end

  // Flush accepts (and drops) whatever the decoder presents.
  always_comb begin
    id_ready = (act == ISSUE_NORMAL) || (act == ISSUE_FLUSH);
  end

  always_comb begin
    ex_d = ex_q;
    unique case (act)
      ISSUE_FLUSH:  ex_d = '0;
      ISSUE_HOLD:   ex_d = ex_q;
      ISSUE_HAZARD: ex_d = '0;
      ISSUE_NORMAL: begin
        if (id_valid) begin
          ex_d.valid   = 1'b1;
          ex_d.op      = id_op;
          ex_d.rd_id   = id_rd_id;
          ex_d.rd_we   = id_rd_we;
          ex_d.mem_we  = id_mem_we;
          ex_d.mem_re  = id_mem_re;
          ex_d.rs1_id  = id_rs1_id;
          ex_d.rs1_use = id_rs1_use;
          ex_d.rs2_id  = id_rs2_id;
          ex_d.rs2_use = id_rs2_use;
          ex_d.src1    = id_src1;
          ex_d.src2    = id_src2;
          ex_d.imm     = id_imm;
        end else begin
          ex_d = '0;
        end
      end
      default: ex_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((act == ISSUE_HAZARD) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // MEM beats WB; a load in MEM has no data yet, so it is skipped (the
  // hazard bubble guarantees the consumer picks it up from WB instead).
  function automatic logic [31:0] fwd_operand(
    input logic        use_op,
    input logic [4:0]  rs_id,
    input logic [31:0] stored
  );
    logic [31:0] val;
    val = stored;
    if (use_op && (rs_id != '0)) begin
      if (mem_rd_we && (mem_rd_id == rs_id) && !mem_re_nz) begin
        val = mem_data;
      end else if (wb_rd_we && (wb_rd_id == rs_id)) begin
        val = wb_data;
      end
    end
    return val;
  endfunction

  always_comb begin
    ex_src1 = fwd_operand(ex_q.rs1_use, ex_q.rs1_id, ex_q.src1);
    ex_src2 = fwd_operand(ex_q.rs2_use, ex_q.rs2_id, ex_q.src2);
  end

  always_comb begin
    ex_valid  = ex_q.valid;
    ex_op     = ex_q.op;
    ex_rd_id  = ex_q.rd_id;
    ex_rd_we  = ex_q.rd_we;
    ex_mem_we = ex_q.mem_we;
    ex_mem_re = ex_q.mem_re;
    ex_imm    = ex_q.imm;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue-stage controller sitting between the decoder and the ALU: it owns the ID/EX pipeline register, forwards in-flight results into ALU operands, inserts a one-cycle bubble on load-use hazards, and squashes instructions on redirect. Its outputs feed the ALU's op/rd/mem/src/imm inputs directly. It also counts stall cycles for performance debug.

## Interface
- OP_W, `ALU_OP_NUM: width of the one-hot ALU op vector
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decoder presents an instruction
- id_ready  out  1  instruction accepted this cycle
- id_op  in  OP_W  one-hot ALU op
- id_rd_id / id_rd_we  in  5 / 1  destination register, write enable
- id_mem_we / id_mem_re  in  4 / 5  store byte enables, load type (nonzero = load)
- id_rs1_id / id_rs2_id  in  5 / 5  source register indices
- id_rs1_use / id_rs2_use  in  1 / 1  operand actually read from regfile (rs2_use=0 when immediate form; src2 is then 0)
- id_src1 / id_src2 / id_imm  in  32 each  regfile values, immediate
- ex_stall  in  1  downstream (memory) wait; freeze EX
- flush  in  1  branch/jump redirect; kill ID and EX contents
- mem_rd_id / mem_rd_we / mem_re_nz / mem_data  in  5 / 1 / 1 / 32  instruction in MEM stage
- wb_rd_id / wb_rd_we / wb_data  in  5 / 1 / 32  instruction in WB stage
- ex_valid  out  1  EX register holds a real instruction
- ex_op, ex_rd_id, ex_rd_we, ex_mem_we, ex_mem_re, ex_imm  out  as id_*  registered fields to ALU
- ex_src1 / ex_src2  out  32  forwarded operands to ALU
- stall_cnt  out  32  saturating count of load-use bubble cycles

## Operation
- EX register holds: valid, op, rd_id, rd_we, mem_we, mem_re, rs1/rs2 id+use, src1, src2, imm.
- Bubble = valid 0 and op, rd_we, mem_we, mem_re all 0 (ALU output 0, no side effects).
- Load-use hazard (hz): ex_valid & ex_mem_re!=0 & ex_rd_id!=0 & id_valid & ((id_rs1_use & id_rs1_id==ex_rd_id) | (id_rs2_use & id_rs2_id==ex_rd_id)).
- Per-edge priority: rst > flush > ex_stall > hz > normal.
  - rst: EX ← bubble, stall_cnt ← 0.
  - flush: EX ← bubble; id_ready=1 so decoder instruction is dropped.
  - ex_stall: EX holds; id_ready=0.
  - hz: EX ← bubble; id_ready=0; stall_cnt += 1 (saturate at 0xFFFF_FFFF).
  - normal: EX ← id fields if id_valid, else bubble; id_ready=1.
- Forwarding per operand n∈{1,2}, only when ex_rsn_use & ex_rsn_id!=0:
  - MEM match (mem_rd_we & mem_rd_id==ex_rsn_id & !mem_re_nz) → mem_data (highest priority).
  - else WB match (wb_rd_we & wb_rd_id==ex_rsn_id) → wb_data.
  - else stored src value. Operands with use=0 pass stored value unchanged (src2 stays 0 for immediate forms).
- x0 never forwarded and never hazards.

## Timing
- Reset: ex_valid=0, all ex_* control fields 0, ex_src1/src2/imm 0, stall_cnt=0.
- id_ready combinational from id_*, EX register, flush, ex_stall; no dependence on id_ready itself.
- ex_src1/ex_src2 combinational from EX register and mem_/wb_ inputs (forwarding mux after the register).
- Latency: accepted instruction appears on ex_* the next cycle.
- Load-use: exactly one bubble; dependent enters EX one cycle late and takes load data via WB forward.
- flush and hz in same cycle: flush wins, no stall_cnt increment.
- ex_stall and hz in same cycle: hold, no increment.
- rst mid-stall: next cycle EX bubble, id_ready=1 once rst low.

## Test plan
- Back-to-back add x5=x1+x2 then add x6=x5+x3, mem_data=0x10 for x5 → second op ex_src1=0x10, no bubble, stall_cnt=0.
- lw x7 then add x8=x7+x1 → id_ready=0 one cycle, bubble ex_valid=0, then add issues with ex_src1=wb_data (0xDEADBEEF), stall_cnt=1.
- MEM and WB both write x9 (0xAAAA / 0xBBBB), consumer reads x9 → ex_src1=0xAAAA; rd=x0 match with mem_data=5 → no forward.
- addi x4=x4+12 (rs2_use=0) while WB writes x4's rs2 index → ex_src2 stays 0, ex_imm=12.
- flush asserted with hazard pending → next cycle ex_valid=0, stall_cnt unchanged, id instruction dropped.
- ex_stall high 3 cycles → ex_* frozen, id_ready=0; rst during stall → all outputs zero next cycle.
